// File: rtl/z80_bus_responder.sv
// Z80 bus responder: memory, I/O ports, wait-state insertion,
// timer interrupt with acknowledge, and NMI trigger port.
module z80_bus_responder #(
  parameter int          ADDR_W     = 16,
  parameter int          MEM_AW     = 10,
  parameter int          MEM_WAIT   = 0,
  parameter int          IO_WAIT    = 1,
  parameter int          NUM_PORTS  = 4,
  parameter int          INT_PERIOD = 0,
  parameter logic [7:0]  INT_VECTOR = 8'hFF,
  parameter logic [7:0]  NMI_PORT   = 8'hFE
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [7:0]        DO,
  output logic [7:0]        DI,
  input  logic              WR,
  input  logic              MREQ,
  input  logic              IORQ,
  input  logic              M1,
  input  logic              HALT,
  output logic              WAIT,
  output logic              INT,
  output logic              NMI,
  output logic              BUS_ERR
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [3:0]  MW  = 4'(MEM_WAIT);
  localparam logic [3:0]  IW  = 4'(IO_WAIT);
  localparam logic [31:0] PER = 32'(INT_PERIOD);

  typedef enum logic [1:0] {IDLE, WAITING, HOLD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] a_q;
  logic              wr_q, m1_q, io_q;
  logic [3:0]        cnt;
  logic [1:0]        ncnt;
  logic [31:0]       tcnt;
  logic [7:0]        mem   [2**MEM_AW];
  logic [7:0]        ports [NUM_PORTS];

  logic              one, both, go;
  logic [ADDR_W-1:0] a_x;
  logic              wr_x, m1_x, io_x;
  logic [3:0]        n_x;
  logic [MEM_AW-1:0] m_idx;
  logic [PW-1:0]     p_idx;
  logic              io_in, expire;
  logic              mem_rd, mem_we, ack, io_wr, io_rd, nmi_hit;
  logic              unused_ok;

  // In IDLE the live bus is used so zero-wait accesses land on the capture edge
  always_comb begin
    one  = MREQ ^ IORQ;
    both = MREQ & IORQ;
    n_x  = IORQ ? IW : MW;
    a_x  = ADDR;
    wr_x = WR;
    m1_x = M1;
    io_x = IORQ;
    go   = 1'b0;
    if (state == WAITING) begin
      a_x  = a_q;
      wr_x = wr_q;
      m1_x = m1_q;
      io_x = io_q;
      go   = (cnt == 4'd0);
    end else if (state == IDLE) begin
      go = one && (n_x == 4'd0);
    end
  end

  assign m_idx   = a_x[MEM_AW-1:0];
  assign p_idx   = a_x[PW-1:0];
  assign io_in   = {24'd0, a_x[7:0]} < NUM_PORTS;
  assign mem_rd  = go & ~io_x & ~wr_x;
  assign mem_we  = go & ~io_x & wr_x & ~RESET;
  assign ack     = go & io_x & m1_x;
  assign io_wr   = go & io_x & ~m1_x & wr_x;
  assign io_rd   = go & io_x & ~m1_x & ~wr_x;
  assign nmi_hit = io_wr & (a_x[7:0] == NMI_PORT);
  assign expire  = (PER != 32'd0) && (tcnt == PER - 32'd1);
  assign unused_ok = ^{HALT, a_x};

  always_ff @(posedge CLK) begin
    if (mem_we) mem[m_idx] <= DO;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      WAIT    <= 1'b0;
      INT     <= 1'b0;
      NMI     <= 1'b0;
      BUS_ERR <= 1'b0;
      DI      <= 8'h00;
      cnt     <= 4'd0;
      ncnt    <= 2'd0;
      tcnt    <= 32'd0;
      a_q     <= '0;
      wr_q    <= 1'b0;
      m1_q    <= 1'b0;
      io_q    <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++)
        ports[i] <= 8'h00;
    end else begin
      tcnt <= (expire || PER == 32'd0) ? 32'd0 : tcnt + 32'd1;
      if (expire)   INT <= 1'b1;
      else if (ack) INT <= 1'b0;

      NMI  <= nmi_hit | (ncnt > 2'd1);
      if (nmi_hit)            ncnt <= 2'd2;
      else if (ncnt != 2'd0)  ncnt <= ncnt - 2'd1;

      case (state)
        IDLE: begin
          if (both) begin
            BUS_ERR <= 1'b1;
          end else if (one) begin
            a_q  <= ADDR;
            wr_q <= WR;
            m1_q <= M1;
            io_q <= IORQ;
            if (n_x == 4'd0) begin
              state <= HOLD;
            end else begin
              WAIT  <= 1'b1;
              cnt   <= n_x - 4'd1;
              state <= WAITING;
            end
          end
        end
        WAITING: begin
          if (cnt == 4'd0) begin
            WAIT  <= 1'b0;
            state <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (!MREQ && !IORQ) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      unique case (1'b1)
        mem_rd:  DI <= mem[m_idx];
        ack:     DI <= INT_VECTOR;
        io_wr:   if (io_in) ports[p_idx] <= DO;
        io_rd:   DI <= io_in ? ports[p_idx] : 8'hFF;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench: u0 has zero memory waits and a 20-cycle INT timer,
// u1 has three memory waits and no timer.
module tb_z80_bus_responder;

  logic        clk = 1'b0;
  logic        rst, wr, m1, halt;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        mreq0, iorq0, mreq1, iorq1;
  logic [7:0]  di0, di1;
  logic        wait0, int0, nmi0, berr0;
  logic        wait1, int1, nmi1, berr1;

  int errs = 0;
  int checks = 0;
  int nmi_hi = 0;
  int wc;
  int n0;

  always #5 clk = ~clk;

  z80_bus_responder #(
    .MEM_WAIT(0), .IO_WAIT(1), .INT_PERIOD(20)
  ) u0 (
    .CLK(clk), .RESET(rst), .ADDR(addr), .DO(dout), .DI(di0),
    .WR(wr), .MREQ(mreq0), .IORQ(iorq0), .M1(m1), .HALT(halt),
    .WAIT(wait0), .INT(int0), .NMI(nmi0), .BUS_ERR(berr0)
  );

  z80_bus_responder #(
    .MEM_WAIT(3), .IO_WAIT(1), .INT_PERIOD(0)
  ) u1 (
    .CLK(clk), .RESET(rst), .ADDR(addr), .DO(dout), .DI(di1),
    .WR(wr), .MREQ(mreq1), .IORQ(iorq1), .M1(m1), .HALT(halt),
    .WAIT(wait1), .INT(int1), .NMI(nmi1), .BUS_ERR(berr1)
  );

  always @(negedge clk) if (nmi0) nmi_hi++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic wt(input int u);
    return (u == 0) ? wait0 : wait1;
  endfunction

  task automatic bus(input int u, input logic io, input logic w,
                     input logic m, input logic [15:0] a,
                     input logic [7:0] d, output int n);
    addr = a;
    dout = d;
    wr   = w;
    m1   = m;
    if (u == 0) begin mreq0 = ~io; iorq0 = io; end
    else        begin mreq1 = ~io; iorq1 = io; end
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wt(u)) n++;
      else break;
    end
    mreq0 = 0; iorq0 = 0; mreq1 = 0; iorq1 = 0;
    wr = 0; m1 = 0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1; wr = 0; m1 = 0; halt = 0;
    addr = '0; dout = '0;
    mreq0 = 0; iorq0 = 0; mreq1 = 0; iorq1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_di",    di0,   8'h00);
    chk("rst_wait",  wait0, 1'b0);
    chk("rst_int",   int0,  1'b0);
    chk("rst_nmi",   nmi0,  1'b0);
    chk("rst_berr",  berr0, 1'b0);
    chk("rst_wait1", wait1, 1'b0);

    halt = 1;
    rst  = 0;
    repeat (19) @(negedge clk);
    chk("int_early", int0, 1'b0);
    @(negedge clk);
    chk("int_rise", int0, 1'b1);
    halt = 0;

    bus(0, 1, 0, 1, 16'h0000, 8'h00, wc);
    chk("ack_wait", wc, 1);
    chk("ack_di", di0, 8'hFF);
    chk("ack_int", int0, 1'b0);

    bus(0, 0, 1, 0, 16'h0010, 8'hA5, wc);
    chk("mw_wait", wc, 0);
    chk("mw_di", di0, 8'hFF);
    bus(0, 0, 0, 0, 16'h0010, 8'h00, wc);
    chk("mr_wait", wc, 0);
    chk("mr_di", di0, 8'hA5);

    bus(0, 1, 1, 0, 16'h0002, 8'h55, wc);
    chk("iow_wait", wc, 1);
    bus(0, 1, 0, 0, 16'h0002, 8'h00, wc);
    chk("ior_di", di0, 8'h55);
    bus(0, 1, 0, 0, 16'h0040, 8'h00, wc);
    chk("ior_oob", di0, 8'hFF);
    bus(0, 1, 0, 0, 16'h0001, 8'h00, wc);
    chk("ior_p1", di0, 8'h00);

    n0 = nmi_hi;
    bus(0, 1, 1, 0, 16'h00FE, 8'h12, wc);
    repeat (3) @(negedge clk);
    chk("nmi_len", nmi_hi - n0, 2);

    addr = 16'h0010; dout = 8'h77; wr = 1;
    mreq0 = 1; iorq0 = 1;
    @(negedge clk);
    chk("berr_set", berr0, 1'b1);
    chk("berr_wait", wait0, 1'b0);
    mreq0 = 0; iorq0 = 0; wr = 0;
    @(negedge clk);
    bus(0, 0, 0, 0, 16'h0010, 8'h00, wc);
    chk("berr_noacc", di0, 8'hA5);
    chk("berr_stick", berr0, 1'b1);

    bus(1, 0, 1, 0, 16'h0010, 8'h3C, wc);
    chk("mw3_wait", wc, 3);
    bus(1, 0, 0, 0, 16'h0410, 8'h00, wc);
    chk("alias_wait", wc, 3);
    chk("alias_di", di1, 8'h3C);
    chk("int_off", int1, 1'b0);

    addr = 16'h0010; dout = 8'hEE; wr = 1; mreq1 = 1;
    @(negedge clk);
    chk("rw_wait_a", wait1, 1'b1);
    @(negedge clk);
    chk("rw_wait_b", wait1, 1'b1);
    rst = 1;
    @(negedge clk);
    chk("rw_wait_clr", wait1, 1'b0);
    chk("rw_berr_clr", berr0, 1'b0);
    rst = 0; mreq1 = 0; wr = 0;
    @(negedge clk);
    chk("rw_di_rst", di1, 8'h00);
    bus(1, 0, 0, 0, 16'h0010, 8'h00, wc);
    chk("mem_kept", di1, 8'h3C);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/z80_bus_responder.md
Z80_BUS_RESPONDER -- requirements
Module: z80_bus_responder

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_W, 16, CPU address width.
REQ-002 SHALL have parameter MEM_AW, 10, memory index width; depth = 2**MEM_AW bytes.
REQ-003 SHALL have parameter MEM_WAIT, 0, wait cycles per memory access (0..15).
REQ-004 SHALL have parameter IO_WAIT, 1, wait cycles per I/O or interrupt-acknowledge access (0..15).
REQ-005 SHALL have parameter NUM_PORTS, 4, count of I/O registers (power of 2, 1..256).
REQ-006 SHALL have parameter INT_PERIOD, 0, INT timer period in CLK cycles; 0 disables the timer.
REQ-007 SHALL have parameter INT_VECTOR, 8'hFF, byte returned on interrupt acknowledge.
REQ-008 SHALL have parameter NMI_PORT, 8'hFE, I/O address low byte whose write pulses NMI.
REQ-009 SHALL have ports (name, direction, width, meaning): CLK, in, 1, sole clock, rising edge.
REQ-010 SHALL have port RESET, in, 1, synchronous active-high reset.
REQ-011 SHALL have port ADDR, in, ADDR_W, CPU address.
REQ-012 SHALL have port DO, in, 8, CPU write data.
REQ-013 SHALL have port DI, out, 8, read data to CPU, registered.
REQ-014 SHALL have ports WR, MREQ, IORQ, M1, HALT, in, 1 each, active-high CPU strobes.
REQ-015 SHALL have ports WAIT, INT, NMI, out, 1 each, active-high, registered.
REQ-016 SHALL have port BUS_ERR, out, 1, sticky flag set on illegal strobe combination.

Function
REQ-017 SHALL implement FSM states IDLE, WAITING, HOLD.
REQ-018 In IDLE, on an edge with exactly one of MREQ/IORQ high, SHALL capture ADDR, WR, M1, and access type.
REQ-019 Wait count N SHALL be MEM_WAIT for MREQ and IO_WAIT for IORQ.
REQ-020 If N=0, SHALL perform the access at the capture edge and enter HOLD.
REQ-021 If N>0, SHALL set WAIT=1 at the capture edge and enter WAITING.
REQ-022 In WAITING, SHALL hold WAIT high for exactly N cycles, clear WAIT, perform the access at the Nth edge, and enter HOLD.
REQ-023 Memory read SHALL load DI with mem[ADDR[MEM_AW-1:0]]; higher address bits are ignored, so addresses alias.
REQ-024 Memory write (WR=1) SHALL store DO into mem[ADDR[MEM_AW-1:0]]; DI is unchanged.
REQ-025 I/O read SHALL return port[ADDR[log2(NUM_PORTS)-1:0]] when ADDR[7:0] < NUM_PORTS, else 8'hFF.
REQ-026 I/O write SHALL store DO into the indexed port when ADDR[7:0] < NUM_PORTS, else discard it.
REQ-027 An I/O write with ADDR[7:0]=NMI_PORT SHALL drive NMI high for exactly 2 cycles starting the cycle after the access edge; a retrigger restarts the 2-cycle count.
REQ-028 IORQ with M1=1 SHALL be an interrupt acknowledge: DI=INT_VECTOR, INT cleared at the access edge, no port access.
REQ-029 HOLD SHALL return to IDLE on the first edge with MREQ=0 and IORQ=0; exactly one access occurs per strobe assertion.
REQ-030 MREQ=1 and IORQ=1 together in IDLE SHALL set BUS_ERR, perform no access, and keep the FSM in IDLE.
REQ-031 With INT_PERIOD>0, a free-running counter SHALL set INT=1 every INT_PERIOD cycles; INT stays high until acknowledged.
REQ-032 If acknowledge and timer expiry fall on the same edge, INT SHALL remain 1.
REQ-033 The INT timer SHALL keep counting while HALT=1; HALT has no other effect.
REQ-034 DI SHALL hold its last driven value between accesses.

Reset
REQ-035 RESET=1 at an edge SHALL force IDLE and set WAIT=0, INT=0, NMI=0, BUS_ERR=0, DI=8'h00, all I/O ports=0, and INT timer=0.
REQ-036 RESET SHALL take effect mid-access: a pending access is abandoned with no write, and WAIT=0 the following cycle.
REQ-037 Memory contents SHALL NOT be altered by RESET.

Verification
REQ-038 Test: MEM_WAIT=0, write 8'hA5 to 16'h0010, then read it -> WAIT never high, DI=8'hA5 after the read capture edge.
REQ-039 Test: MEM_WAIT=3, memory read of 16'h0410 holding 8'h3C with MEM_AW=10 -> WAIT high exactly 3 cycles, DI=mem[16'h0010]=8'h3C.
REQ-040 Test: IO_WAIT=1, write 8'h55 to port 2 and read it back -> DI=8'h55; read of port 8'h40 -> DI=8'hFF.
REQ-041 Test: INT_PERIOD=20 -> INT rises at cycle 20 after reset; IORQ+M1 -> DI=8'hFF and INT=0.
REQ-042 Test: I/O write to 8'hFE -> NMI high exactly 2 cycles.
REQ-043 Test: MREQ=IORQ=1 -> BUS_ERR=1 with no access; RESET=1 during WAITING -> WAIT=0 next cycle and memory is unchanged.
